// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl -- walks the duty ratio applied to the pwm block toward a
// requested target in bounded steps (soft start/stop). Each step is issued
// as a level request (o_pwm_update/o_pwm_ratio) held until the pwm block
// acknowledges with i_pwm_done. A fixed hold time follows each acknowledged
// step. A step that is never acknowledged times out and parks the ramp.
//
// Optional feature macro: PWM_RAMP_BRAKE_EN (adds i_brake emergency stop).
//
// Ports
//   i_clock          main clock
//   i_reset          synchronous, active-high reset
//   i_enable         allow new steps to start
//   i_target_ratio   requested duty (out of 255)
//   i_target_valid   strobe: latch i_target_ratio, clear o_timeout_err
//   i_brake          emergency stop to ratio 0 (PWM_RAMP_BRAKE_EN only)
//   i_pwm_done       pulse from pwm: requested ratio applied
//   o_pwm_ratio      ratio presented to pwm, stable while o_pwm_update high
//   o_pwm_update     level request to pwm, held until i_pwm_done
//   o_current_ratio  last ratio acknowledged by pwm
//   o_ramp_busy      high in any state other than IDLE
//   o_ramp_done      1-cycle pulse when current ratio reaches the target
//   o_timeout_err    sticky: a step timed out
//
// State table
//   ST_IDLE | waiting; decides the next step when enabled and off target
//   ST_REQ  | request outstanding; waits for pwm_done or timeout
//   ST_HOLD | settling time after an acknowledged step

module pwm_ramp_ctrl #(
    parameter int RAMP_STEP    = 4,
    parameter int HOLD_CYCLES  = 256,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_target_ratio,
    input  logic       i_target_valid,
`ifdef PWM_RAMP_BRAKE_EN
    input  logic       i_brake,
`endif
    input  logic       i_pwm_done,
    output logic [7:0] o_pwm_ratio,
    output logic       o_pwm_update,
    output logic [7:0] o_current_ratio,
    output logic       o_ramp_busy,
    output logic       o_ramp_done,
    output logic       o_timeout_err
);

    localparam int CNT_MAX = (DONE_TIMEOUT > HOLD_CYCLES) ? DONE_TIMEOUT : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LOAD   = CW'(DONE_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [8:0]    STEP9     = 9'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          r_state, w_state_n;
    logic [7:0]      r_target, w_target_n;
    logic [7:0]      r_current, w_current_n;
    logic [7:0]      r_pwm_ratio, w_ratio_n;
    logic            r_pwm_update, w_update_n;
    logic            r_ramp_done, w_done_n;
    logic            r_timeout_err, w_err_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;

    logic            w_brake;
    logic            w_up;
    logic [8:0]      w_cur9, w_tgt9, w_diff9, w_step9, w_next9;
    logic [7:0]      w_next8;

`ifdef PWM_RAMP_BRAKE_EN
    assign w_brake = i_brake;
`else
    assign w_brake = 1'b0;
`endif

    // Step arithmetic in 9 bits so the clamp against the remaining distance
    // can never wrap; the saturation on bit 8 is a guard only.
    assign w_cur9  = {1'b0, r_current};
    assign w_tgt9  = {1'b0, r_target};
    assign w_up    = (w_tgt9 > w_cur9);
    assign w_diff9 = w_up ? (w_tgt9 - w_cur9) : (w_cur9 - w_tgt9);
    assign w_step9 = (w_diff9 < STEP9) ? w_diff9 : STEP9;
    assign w_next9 = w_up ? (w_cur9 + w_step9) : (w_cur9 - w_step9);
    assign w_next8 = w_next9[8] ? 8'hFF : w_next9[7:0];

    always_comb begin
        w_state_n   = r_state;
        w_target_n  = r_target;
        w_current_n = r_current;
        w_ratio_n   = r_pwm_ratio;
        w_update_n  = r_pwm_update;
        w_done_n    = 1'b0;
        w_err_n     = r_timeout_err;
        w_cnt_n     = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (i_enable && !r_timeout_err && (r_current != r_target) && !w_brake) begin
                    w_ratio_n  = w_next8;
                    w_update_n = 1'b1;
                    w_cnt_n    = TO_LOAD;
                    w_state_n  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_pwm_done) begin
                    w_current_n = r_pwm_ratio;
                    w_update_n  = 1'b0;
                    w_done_n    = (r_pwm_ratio == r_target);
                    w_cnt_n     = HOLD_LOAD;
                    w_state_n   = ST_HOLD;
                end else if (r_cnt == '0) begin
                    w_err_n    = 1'b1;
                    w_update_n = 1'b0;
                    w_state_n  = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: begin
                w_update_n = 1'b0;
                w_state_n  = ST_IDLE;
            end
        endcase

        // A new target is only latched; any in-flight step still finishes.
        if (i_target_valid && !w_brake) begin
            w_target_n = i_target_ratio;
            w_err_n    = 1'b0;
        end

`ifdef PWM_RAMP_BRAKE_EN
        // Brake jumps straight to a single zero request. The zero request
        // itself is left to run so a held brake does not keep restarting it.
        if (i_brake) begin
            w_target_n = 8'd0;
            if (!((r_state == ST_REQ) && (r_pwm_ratio == 8'd0))) begin
                w_current_n = r_current;
                w_done_n    = 1'b0;
                w_err_n     = r_timeout_err;
                if ((r_current != 8'd0) && !r_timeout_err) begin
                    w_ratio_n  = 8'd0;
                    w_update_n = 1'b1;
                    w_cnt_n    = TO_LOAD;
                    w_state_n  = ST_REQ;
                end else begin
                    w_update_n = 1'b0;
                    w_cnt_n    = '0;
                    w_state_n  = ST_IDLE;
                end
            end
        end
`endif
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_target      <= 8'd0;
            r_current     <= 8'd0;
            r_pwm_ratio   <= 8'd0;
            r_pwm_update  <= 1'b0;
            r_ramp_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_n;
            r_target      <= w_target_n;
            r_current     <= w_current_n;
            r_pwm_ratio   <= w_ratio_n;
            r_pwm_update  <= w_update_n;
            r_ramp_done   <= w_done_n;
            r_timeout_err <= w_err_n;
            r_cnt         <= w_cnt_n;
        end
    end

    assign o_pwm_ratio     = r_pwm_ratio;
    assign o_pwm_update    = r_pwm_update;
    assign o_current_ratio = r_current;
    assign o_ramp_busy     = (r_state != ST_IDLE);
    assign o_ramp_done     = r_ramp_done;
    assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: a small pwm responder acknowledges requests,
// expected request ratios are queued from a stepping model and compared as
// each request rises.

module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] target_ratio;
    logic       target_valid;
`ifdef PWM_RAMP_BRAKE_EN
    logic       brake;
`endif
    logic       pwm_done;
    logic [7:0] pwm_ratio;
    logic       pwm_update;
    logic [7:0] current_ratio;
    logic       ramp_busy;
    logic       ramp_done;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int q[$];
    int n_req = 0;
    int n_rdone = 0;
    int n_upd_cyc = 0;
    int lat = 0;
    int exp_r;
    int prev_upd = 0;
    int tie0 = 0;
    int snap;
    int ok;

    always #5 clk = ~clk;

    pwm_ramp_ctrl dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_enable       (enable),
        .i_target_ratio (target_ratio),
        .i_target_valid (target_valid),
`ifdef PWM_RAMP_BRAKE_EN
        .i_brake        (brake),
`endif
        .i_pwm_done     (pwm_done),
        .o_pwm_ratio    (pwm_ratio),
        .o_pwm_update   (pwm_update),
        .o_current_ratio(current_ratio),
        .o_ramp_busy    (ramp_busy),
        .o_ramp_done    (ramp_done),
        .o_timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference stepping model: queue every ratio the ramp should request.
    task automatic push_ramp(input int from, input int to);
        int c;
        c = from;
        while (c != to) begin
            if (to > c) c = c + (((to - c) < 4) ? (to - c) : 4);
            else        c = c - (((c - to) < 4) ? (c - to) : 4);
            q.push_back(c);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic pulse_target(input int v);
        target_ratio = 8'(v);
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic wait_cur(input string tag, input int expv, input int budget);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (current_ratio == 8'(expv) && !ramp_busy) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_settle"}, ok, 1);
        chk({tag, "_cur"}, current_ratio, expv);
        chk({tag, "_queue"}, q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    // Monitor plus pwm responder (acks each request a few cycles after it rises).
    always @(negedge clk) begin
        if (rst) begin
            prev_upd = 0;
            lat      = 0;
            pwm_done = 1'b0;
        end else begin
            if (pwm_update && prev_upd == 0) begin
                n_req++;
                exp_r = (q.size() > 0) ? q.pop_front() : -1;
                chk("req_ratio", pwm_ratio, exp_r);
            end
            if (pwm_update) n_upd_cyc++;
            if (ramp_done) n_rdone++;
            prev_upd = pwm_update;
            if (pwm_done) begin
                pwm_done = 1'b0;
                lat      = 0;
            end else if (pwm_update && tie0 == 0) begin
                if (lat == 2) begin
                    pwm_done = 1'b1;
                    lat      = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        target_ratio = 8'd0;
        target_valid = 1'b0;
        pwm_done     = 1'b0;
`ifdef PWM_RAMP_BRAKE_EN
        brake        = 1'b0;
`endif
        do_reset();
        chk("rst_update", pwm_update, 0);
        chk("rst_ratio", pwm_ratio, 0);
        chk("rst_current", current_ratio, 0);
        chk("rst_busy", ramp_busy, 0);
        chk("rst_done", ramp_done, 0);
        chk("rst_err", timeout_err, 0);

        // Ramp up 0 -> 100 in 25 steps of 4.
        enable  = 1'b1;
        n_rdone = 0;
        snap    = n_req;
        push_ramp(0, 100);
        pulse_target(100);
        wait_cur("t1", 100, 12000);
        chk("t1_nreq", n_req - snap, 25);
        chk("t1_rdone", n_rdone, 1);

        // Down to 10, then a clamped 3-count step to 7.
        push_ramp(100, 10);
        pulse_target(10);
        wait_cur("t2a", 10, 12000);
        n_rdone = 0;
        snap    = n_req;
        q.push_back(7);
        pulse_target(7);
        wait_cur("t2b", 7, 2000);
        chk("t2_nreq", n_req - snap, 1);
        chk("t2_rdone", n_rdone, 1);

        // Timeout: pwm never answers.
        do_reset();
        tie0      = 1;
        n_upd_cyc = 0;
        snap      = n_req;
        q.push_back(4);
        pulse_target(50);
        ok = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                ok = 1;
                break;
            end
        end
        chk("t3_err", ok, 1);
        chk("t3_upd_cycles", n_upd_cyc, 1024);
        chk("t3_update", pwm_update, 0);
        chk("t3_current", current_ratio, 0);
        repeat (300) @(negedge clk);
        chk("t3_parked", n_req - snap, 1);
        tie0 = 0;
        push_ramp(0, 50);
        pulse_target(50);
        chk("t3_err_clr", timeout_err, 0);
        wait_cur("t3", 50, 6000);

        // Reverse mid-REQ: 0 -> 200, retarget 20 while 44 is outstanding.
        do_reset();
        n_rdone = 0;
        push_ramp(0, 200);
        pulse_target(200);
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pwm_update && pwm_ratio == 8'd44) begin
                ok = 1;
                break;
            end
        end
        chk("t4_reach44", ok, 1);
        chk("t4_cur40", current_ratio, 40);
        @(negedge clk);
        q.delete();
        push_ramp(44, 20);
        pulse_target(20);
        wait_cur("t4", 20, 5000);
        chk("t4_rdone", n_rdone, 1);

        // Enable low blocks new steps.
        enable = 1'b0;
        snap   = n_req;
        pulse_target(80);
        repeat (300) @(negedge clk);
        chk("t5_noreq", n_req - snap, 0);
        chk("t5_busy", ramp_busy, 0);
        chk("t5_update", pwm_update, 0);
        push_ramp(20, 80);
        enable = 1'b1;
        wait_cur("t5", 80, 6000);

`ifdef PWM_RAMP_BRAKE_EN
        push_ramp(80, 120);
        pulse_target(120);
        wait_cur("t6a", 120, 4000);
        n_rdone = 0;
        snap    = n_req;
        q.push_back(0);
        brake = 1'b1;
        @(negedge clk);
        brake = 1'b0;
        wait_cur("t6", 0, 2000);
        chk("t6_nreq", n_req - snap, 1);
        chk("t6_rdone", n_rdone, 1);
        repeat (300) @(negedge clk);
        chk("t6_stay0", n_req - snap, 1);
`endif

        // Reset while a request is outstanding drops the request.
        q.push_back(4);
        pulse_target(60);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pwm_update) begin
                ok = 1;
                break;
            end
        end
        chk("t7_req", ok, 1);
        tie0 = 1;
        rst  = 1'b1;
        @(negedge clk);
        chk("t7_update", pwm_update, 0);
        chk("t7_current", current_ratio, 0);
        rst  = 1'b0;
        tie0 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
